// File: rtl/seq_piso.sv
// Purpose: parallel-in/serial-out shifter, MSB first, with a one-word holding buffer so words can stream back to back.
// Latency: the MSB of a word accepted into an idle block appears the cycle after the accepting edge; bit i follows i cycles later.
// Backpressure: in_ready = !hold_full, so the block takes a second word while shifting and stalls only while that word waits.
// Ports: clk/reset (sync, active-high) | in_data/in_valid/in_ready (word input handshake)
//        out/out_valid (serial bit stream, 0 when not valid) | busy (shifter or holding buffer occupied)
module seq_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out,
    output logic         out_valid,
    output logic         busy
);

    localparam int CW = $clog2(W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hold_q, hold_d;
    logic           hold_full_q, hold_full_d;

    logic           accept;
    logic           last_bit;

    assign in_ready = !hold_full_q;
    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_q == CW'(W - 1));

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sreg_d = {sreg_q[W-2:0], 1'b0};
                    cnt_d  = cnt_q + CW'(1);
                    // Mid-word arrivals park in the holding buffer.
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Buffered word follows the last bit with no gap.
                    // in_ready is low here, so no new word can collide.
                    sreg_d      = hold_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    // Word arriving on the last bit bypasses the buffer.
                    sreg_d = in_data;
                    cnt_d  = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign out_valid = (state_q == SHIFT);
    assign out       = (state_q == SHIFT) && sreg_q[W-1];
    assign busy      = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_seq_piso.sv
// Purpose: self-checking bench for seq_piso (W=8): scoreboard of expected serial bits plus directed corner sequences.
// Latency: expected bits are queued when an accept is seen and compared whenever out_valid is high.
// Backpressure: the driver holds in_valid until in_ready is seen, bounded by a cycle budget.
module tb_seq_piso;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         out;
    logic         out_valid;
    logic         busy;

    int tests;
    int fails;
    int cyc;
    logic exp_q[$];

    typedef struct {
        logic [W-1:0] data;
        int           gap;
    } vec_t;

    vec_t tbl[6];

    seq_piso #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: compare the current output, then record what the next edge will accept.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bit", 32'(out_valid), 32'(0));
            end else begin
                check("serial_bit", 32'(out), 32'(exp_q.pop_front()));
            end
        end else begin
            check("idle_out_zero", 32'(out), 32'(0));
        end
        if (reset) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            for (int b = W - 1; b >= 0; b--) exp_q.push_back(in_data[b]);
        end
    end

    // Offer one word and hold it until accepted; acc is the cycle count at the accepting edge.
    task automatic send(input logic [W-1:0] w, output int acc);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'(1));
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, a2;
        logic [W-1:0] w;

        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, a2;
        logic [W-1:0] w;

        tbl[0] = '{data: 8'h81, gap: 0};
        tbl[1] = '{data: 8'h5A, gap: 0};
        tbl[2] = '{data: 8'hC3, gap: 1};
        tbl[3] = '{data: 8'h01, gap: 3};
        tbl[4] = '{data: 8'h80, gap: 0};
        tbl[5] = '{data: 8'h6E, gap: 12};

        tests    = 0;
        fails    = 0;
        cyc      = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_out", 32'(out), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        settle(2);

        // Single word E4: MSB the cycle after accept, eight bits, then idle
        w = 8'hE4;
        send(w, a0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("e4_valid", 32'(out_valid), 32'(1));
            check("e4_bit", 32'(out), 32'(w[W-1-i]));
        end
        @(negedge clk);
        check("e4_end_valid", 32'(out_valid), 32'(0));
        check("e4_end_busy", 32'(busy), 32'(0));
        settle(2);

        // FF then 00 back to back: 16 gap-free bits, in_ready low while buffered
        send(8'hFF, a0);
        send(8'h00, a1);
        check("ff00_accept_spacing", 32'(a1 - a0), 32'(1));
        for (int j = 1; j < 2 * W; j++) begin
            @(negedge clk);
            check("ff00_no_gap", 32'(out_valid), 32'(1));
            check("ff00_in_ready", 32'(in_ready), 32'(j >= W));
        end
        @(negedge clk);
        check("ff00_end_valid", 32'(out_valid), 32'(0));
        check("ff00_end_busy", 32'(busy), 32'(0));
        settle(2);

        // Three words offered continuously: third waits for the buffer to drain
        send(8'hA1, a0);
        send(8'hB2, a1);
        send(8'hC3, a2);
        check("three_second_spacing", 32'(a1 - a0), 32'(1));
        check("three_third_spacing", 32'(a2 - a0), 32'(W + 1));
        settle(3 * W + 4);
        check("three_drained", 32'(exp_q.size()), 32'(0));

        // Reset during bit 3 with a buffered word: both discarded
        send(8'hA5, a0);
        send(8'h3C, a1);
        check("rst_mid_busy_before", 32'(busy), 32'(1));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'(0));
        check("rst_mid_in_ready", 32'(in_ready), 32'(1));
        check("rst_mid_busy", 32'(busy), 32'(0));
        // Twenty idle cycles: nothing emitted, nothing busy
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(out_valid), 32'(0));
            check("idle_busy", 32'(busy), 32'(0));
        end
        settle(1);

        // First accept after reset behaves as into an idle block
        w = 8'h4B;
        send(w, a0);
        @(negedge clk);
        check("post_rst_msb_valid", 32'(out_valid), 32'(1));
        check("post_rst_msb", 32'(out), 32'(w[W-1]));
        settle(W + 3);

        // Table-driven word stream with assorted gaps
        for (int t = 0; t < 6; t++) begin
            send(tbl[t].data, a0);
            repeat (tbl[t].gap) begin
                @(posedge clk);
                #1;
            end
        end
        settle(3 * W + 4);
        check("table_drained", 32'(exp_q.size()), 32'(0));
        check("table_idle_busy", 32'(busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_piso.md
SEQ_PISO -- requirements
Module: seq_piso

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the parallel word width in bits (W >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, W bits: the parallel word to serialize.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is offered this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 The block SHALL have port out, output, 1 bit: the serial bit stream, MSB first, for the downstream sequence detector's in.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out carries a real data bit this cycle.
REQ-009 The block SHALL have port busy, output, 1 bit: the shifter or the holding buffer is occupied.

Function
REQ-010 The block SHALL contain a W-bit shift register sreg, a bit counter cnt (0..W-1), a one-word holding buffer buf with flag buf_full, and a 2-state FSM: IDLE, SHIFT.
REQ-011 in_ready SHALL equal !buf_full, combinationally, independent of in_valid.
REQ-012 A word SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-013 An accepted word SHALL load directly into sreg, with cnt=0 and state SHIFT, when the state is IDLE, or when the state is SHIFT with cnt==W-1 and !buf_full; otherwise it SHALL load into buf and set buf_full.
REQ-014 In SHIFT with cnt<W-1, each edge SHALL shift sreg left by one and increment cnt.
REQ-015 In SHIFT with cnt==W-1 and buf_full, the edge SHALL load buf into sreg, set cnt=0, clear buf_full, and stay in SHIFT.
REQ-016 In SHIFT with cnt==W-1, !buf_full and no accept, the edge SHALL move the FSM to IDLE.
REQ-017 out SHALL equal sreg[W-1] in SHIFT and 0 in IDLE; out_valid SHALL be 1 exactly in SHIFT.
REQ-018 Latency: a word accepted at edge k into an idle block SHALL present its MSB during the cycle after edge k, and bit i (MSB=0) during the cycle after edge k+i.
REQ-019 Back-to-back words SHALL be emitted with zero idle cycles between the last bit of one word and the MSB of the next.
REQ-020 busy SHALL equal (state==SHIFT) || buf_full.
REQ-021 in_data SHALL be ignored whenever in_valid is 0 or in_ready is 0; no word SHALL be dropped or duplicated.

Reset
REQ-022 While reset is 1 at an edge: state SHALL become IDLE, cnt=0, sreg=0, and buf_full=0; consequently out=0, out_valid=0, in_ready=1, busy=0.
REQ-023 Reset SHALL take priority over any simultaneous accept or shift, and any partially emitted word and buffered word SHALL be discarded.
REQ-024 After reset deasserts, the first accept SHALL behave as into an idle block (REQ-018).

Verification
REQ-025 W=8, idle, in_data=8'hE4 with in_valid for 1 cycle -> out = 1,1,1,0,0,1,0,0 on 8 consecutive cycles with out_valid=1, then out_valid=0; a downstream detector fed this stream sees 1110010.
REQ-026 Two words 8'hFF then 8'h00, with in_valid held high -> 16 consecutive out_valid cycles (eight 1s, then eight 0s) with no gap; in_ready drops to 0 after the second accept and rises again when the buffer drains.
REQ-027 Three words offered continuously -> the third is accepted only on the edge when buf_full clears, and no word is lost or reordered.
REQ-028 reset asserted during bit 3 of a word, with a buffered word present -> the next cycle shows out_valid=0, in_ready=1, busy=0, and neither word is emitted afterwards.
REQ-029 in_valid=0 for 20 cycles after reset -> out=0, out_valid=0, and busy=0 throughout.
